// File: rtl/program_counter.sv
// Program counter with run/halt/fault control and an optional return stack.
// Define PC_RETURN_STACK_EN to build the call/return stack and FAULT handling.
module program_counter #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inca,
    input  logic       stall,
    input  logic       jmp_en,
    input  logic [7:0] jmp_addr,
    input  logic       call_en,
    input  logic       ret_en,
    input  logic       halt,
    output logic [7:0] PCa,
    output logic       halted,
    output logic       fault,
    output logic       stk_full,
    output logic       stk_empty
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pc;

    assign PCa = pc;

`ifdef PC_RETURN_STACK_EN

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PTR_W-1:0] sp;
    logic [7:0]       stack [STACK_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             active;
    logic             push;

    assign stk_full  = (sp == PTR_W'(STACK_DEPTH));
    assign stk_empty = (sp == '0);

    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = IDX_W'(sp - PTR_W'(1));

    // A request is live only when nothing of higher priority claims the cycle
    assign active = !rst && (state == RUN) && !halt && !stall;
    assign push   = active && !ret_en && call_en && !stk_full;

    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= inca;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_VECTOR;
            state  <= RUN;
            sp     <= '0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        if (ret_en) begin
                            if (stk_empty) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end else begin
                                pc <= stack[rd_idx];
                                sp <= sp - PTR_W'(1);
                            end
                        end else if (call_en) begin
                            if (stk_full) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end else begin
                                pc <= jmp_addr;
                                sp <= sp + PTR_W'(1);
                            end
                        end else if (jmp_en) begin
                            pc <= jmp_addr;
                        end else begin
                            pc <= inca;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                FAULT: begin
                    fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

`else

    logic unused_ret;

    assign unused_ret = ret_en;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign fault      = 1'b0;

    // Without a stack a call is just a jump and a return is a no-op
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_VECTOR;
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        if (call_en || jmp_en) begin
                            pc <= jmp_addr;
                        end else begin
                            pc <= inca;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

`endif

endmodule
